accum_share_ctrl: RTL and testbench
===================================

Name: accum_share_ctrl

Overview:
Controller that shares one W-bit add/subtract unit between two requesters. It arbitrates round-robin, latches the winner's operands and executes one operation. It returns the registered result and the carry/borrow flag to the winner over a valid/ready response channel. It sits between client blocks and the add/sub datapath, and owns all sequencing of that datapath.

Parameters:
W, 4, operand/result width in bits
N_REQ, 2, number of requesters (fixed at 2; grant pointer is 1 bit)

Ports:
Clk  input  1  system clock; all state updates on rising edge
nReset  input  1  reset; synchronous, active-high (asserted = 1 clears state on next Clk edge)
req_valid  input  2  per-requester operation request
req_ready  output  2  per-requester accept; one-hot or zero
req_a  input  2*W  operand A; bits [W-1:0] requester 0, [2W-1:W] requester 1
req_b  input  2*W  operand B, same packing
req_cin  input  2  carry-in (add) / borrow-in (sub) per requester
req_m  input  2  mode per requester: 0 = add, 1 = subtract
rsp_valid  output  2  per-requester result valid; one-hot or zero
rsp_ready  input  2  per-requester result accept
rsp_r  output  W  result of current response
rsp_of  output  1  carry-out (add) or borrow-out (sub) of current response
busy  output  1  high whenever state != IDLE
gnt_id  output  1  requester owning the unit; valid while busy

Behaviour:
- Reset (nReset=1 at an edge): state=IDLE, rr pointer=0 (requester 0 preferred), rsp_r=0, rsp_of=0, gnt_id=0, internal operand regs=0.
- Reset outputs: rsp_valid=00, req_ready=00, busy=0.
- Reset mid-operation aborts any in-flight op; no response is produced for it.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, no requests: stay; req_ready=00.
- IDLE, one req_valid high: grant that requester.
- IDLE, both req_valid high: grant the requester equal to the rr pointer.
- req_ready[g] is asserted combinationally in IDLE for the granted g only. The handshake completes in that cycle: latch a, b, cin and m of g, set gnt_id=g, go to EXEC.
- EXEC (1 cycle), add: {of,r} = a + b + cin.
- EXEC, sub: {borrow,r} = a - b - cin, with of = borrow (1 when a < b + cin, unsigned).
- EXEC: r/of are registered into rsp_r/rsp_of; go to RESP.
- RESP: rsp_valid[gnt_id]=1. rsp_r, rsp_of and gnt_id hold stable until rsp_ready[gnt_id]=1.
- RESP, on response handshake: rr pointer := ~gnt_id, go to IDLE.
- rsp_ready of the non-granted requester is ignored.
- Latency: accept at cycle N -> rsp_valid at N+2. Minimum 3 cycles per operation with rsp_ready held high.
- Requests arriving while busy wait; req_ready stays 0 for them. Requesters must hold valid and operands until accepted.
- Wrap-around: add results are modulo 2^W; sub results are two's-complement modulo 2^W. The flag reports the lost carry/borrow.
- No fairness starvation: with both valid continuously, grants alternate 0,1,0,1.

Decomposition:
- Shared package: W default; mode constants MODE_ADD=0, MODE_SUB=1; state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2 (2'd3 unreachable, decodes to IDLE).
- One sub-module: addsub_w. It is purely combinational (a, b, cin, m -> r, of), instantiated once inside the controller, and also reused by clients needing a standalone add/sub.

Test Plan:
- Reset: drive nReset=1 for 2 edges with req_valid=11 -> req_ready=00, rsp_valid=00, busy=0, rsp_r=0000. Release -> requester 0 granted first.
- Add with carry: requester 0, a=1111, b=0001, cin=0, m=0 -> at N+2, rsp_valid=01, rsp_r=0000, rsp_of=1. Then a=1010, b=0101 -> rsp_r=1111, of=0.
- Subtract: requester 1, a=1111, b=1001, m=1, cin=0 -> rsp_valid=10, rsp_r=0110, of=0. Then a=0111, b=1100 -> rsp_r=1011, of=1 (borrow).
- Contention: both valid continuously for 4 ops, rsp_ready=11 -> grants 0,1,0,1. Each response routes to the right rsp_valid bit. req_ready is never 11.
- Backpressure: hold rsp_ready=00 for 5 cycles in RESP -> rsp_valid, rsp_r, rsp_of and gnt_id stay stable and no new accept occurs. Releasing rsp_ready -> IDLE on the next edge.
- Reset mid-op: assert nReset during EXEC -> next cycle IDLE, rsp_valid=00, and no response is produced for the aborted op.

Source files
------------

// File: rtl/accum_share_ctrl_pkg.sv
// Shared constants for the add/sub sharing controller and its datapath.
package accum_share_ctrl_pkg;

    localparam int W_DEF = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // 2'd3 is never entered; the controller decodes it as IDLE.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/accum_share_ctrl_addsub_w.sv
// Purely combinational W-bit add/subtract with carry/borrow in and out.
module addsub_w
    import accum_share_ctrl_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         m,
    output logic [W-1:0] r,
    output logic         of
);

    logic [W:0] full;

    // One extra bit holds the carry-out (add) or the borrow (sub, bit W set when a < b + cin).
    always_comb begin
        full = '0;
        if (m == MODE_SUB)
            full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
        else
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r  = full[W-1:0];
        of = full[W];
    end

endmodule

// File: rtl/accum_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one add/sub unit between two requesters.
//
// state | meaning
// IDLE  | waiting for a request; req_ready asserted for the selected requester
// EXEC  | latched operands go through addsub_w, result registered
// RESP  | rsp_valid to the winner, result held until its rsp_ready
module accum_share_ctrl
    import accum_share_ctrl_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int N_REQ = 2
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_cin,
    input  logic [N_REQ-1:0]   req_m,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [W-1:0]       rsp_r,
    output logic               rsp_of,
    output logic               busy,
    output logic               gnt_id
);

    logic [1:0]   state;
    logic [1:0]   state_dec;
    logic         rr;
    logic         gnt_sel;
    logic         any_req;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic         op_m;
    logic [W-1:0] sum_r;
    logic         sum_of;

    addsub_w #(.W(W)) u_addsub (
        .a   (op_a),
        .b   (op_b),
        .cin (op_cin),
        .m   (op_m),
        .r   (sum_r),
        .of  (sum_of)
    );

    // Decode state (unused encoding behaves as IDLE) and pick the winner.
    always_comb begin
        state_dec = ST_IDLE;
        if (state == ST_EXEC || state == ST_RESP)
            state_dec = state;
        any_req = |req_valid;
        gnt_sel = 1'b0;
        if (req_valid[0] && req_valid[1])
            gnt_sel = rr;
        else if (req_valid[1])
            gnt_sel = 1'b1;
    end

    // Handshake outputs; req_ready is held off while reset is asserted.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_dec == ST_IDLE && any_req && !nReset)
            req_ready = gnt_sel ? 2'b10 : 2'b01;
        if (state_dec == ST_RESP)
            rsp_valid = gnt_id ? 2'b10 : 2'b01;
        busy = (state_dec != ST_IDLE);
    end

    // Sequencing, operand capture, result registration and round-robin update.
    always_ff @(posedge Clk) begin
        if (nReset) begin
            state  <= ST_IDLE;
            rr     <= 1'b0;
            gnt_id <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            op_cin <= 1'b0;
            op_m   <= MODE_ADD;
            rsp_r  <= '0;
            rsp_of <= 1'b0;
        end else begin
            case (state_dec)
                ST_IDLE: begin
                    state <= ST_IDLE;
                    if (any_req) begin
                        gnt_id <= gnt_sel;
                        op_a   <= gnt_sel ? req_a[2*W-1:W] : req_a[W-1:0];
                        op_b   <= gnt_sel ? req_b[2*W-1:W] : req_b[W-1:0];
                        op_cin <= req_cin[gnt_sel];
                        op_m   <= req_m[gnt_sel];
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_r  <= sum_r;
                    rsp_of <= sum_of;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[gnt_id]) begin
                        rr    <= ~gnt_id;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_share_ctrl.sv
// Directed bench for accum_share_ctrl: vector table for single ops plus hand-written corner sequences.
module tb_accum_share_ctrl;

    localparam int W = 4;

    logic         Clk;
    logic         nReset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]   req_cin;
    logic [1:0]   req_m;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [W-1:0] rsp_r;
    logic         rsp_of;
    logic         busy;
    logic         gnt_id;

    int n_cmp = 0;
    int n_bad = 0;

    accum_share_ctrl #(.W(W), .N_REQ(2)) dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_m     (req_m),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r),
        .rsp_of    (rsp_of),
        .busy      (busy),
        .gnt_id    (gnt_id)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         m;
        logic [W-1:0] r;
        logic         of;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic m);
        if (id) begin
            req_a[2*W-1:W] = a;
            req_b[2*W-1:W] = b;
        end else begin
            req_a[W-1:0] = a;
            req_b[W-1:0] = b;
        end
        req_cin[id] = cin;
        req_m[id]   = m;
    endtask

    // One isolated operation: accept, no response at N+1, response at N+2, then back to IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        logic [1:0] oh;
        int cyc;
        oh = v.id ? 2'b10 : 2'b01;
        @(posedge Clk); #1;
        set_ops(v.id, v.a, v.b, v.cin, v.m);
        req_valid = oh;
        rsp_ready = oh;
        cyc = 0;
        @(negedge Clk);
        while (req_ready !== oh && cyc < 10) begin
            @(negedge Clk);
            cyc++;
        end
        chk($sformatf("vec%0d accept", idx), 32'(req_ready), 32'(oh));
        @(posedge Clk); #1;
        req_valid = 2'b00;
        @(negedge Clk);
        chk($sformatf("vec%0d rsp_valid N+1", idx), 32'(rsp_valid), 32'(2'b00));
        @(negedge Clk);
        chk($sformatf("vec%0d rsp_valid N+2", idx), 32'(rsp_valid), 32'(oh));
        chk($sformatf("vec%0d rsp_r", idx), 32'(rsp_r), 32'(v.r));
        chk($sformatf("vec%0d rsp_of", idx), 32'(rsp_of), 32'(v.of));
        chk($sformatf("vec%0d gnt_id", idx), 32'(gnt_id), 32'(v.id));
        @(posedge Clk); #1;
        rsp_ready = 2'b00;
        @(negedge Clk);
        chk($sformatf("vec%0d idle after", idx), 32'(busy), 32'(1'b0));
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [W-1:0] exp_r;
        logic exp_of;
        int cyc;

        //           id    a        b        cin   m     r        of
        vecs[0] = '{1'b0, 4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1};
        vecs[1] = '{1'b0, 4'b1010, 4'b0101, 1'b0, 1'b0, 4'b1111, 1'b0};
        vecs[2] = '{1'b1, 4'b1111, 4'b1001, 1'b0, 1'b1, 4'b0110, 1'b0};
        vecs[3] = '{1'b1, 4'b0111, 4'b1100, 1'b0, 1'b1, 4'b1011, 1'b1};
        vecs[4] = '{1'b0, 4'b0111, 4'b1000, 1'b1, 1'b0, 4'b0000, 1'b1};
        vecs[5] = '{1'b1, 4'b0101, 4'b0101, 1'b1, 1'b1, 4'b1111, 1'b1};
        vecs[6] = '{1'b0, 4'b1000, 4'b0111, 1'b1, 1'b1, 4'b0000, 1'b0};
        vecs[7] = '{1'b1, 4'b0011, 4'b0100, 1'b1, 1'b0, 4'b1000, 1'b0};

        // Reset with both requesting: nothing is accepted.
        nReset    = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 2'b00;
        req_m     = 2'b00;
        set_ops(1'b0, 4'b0011, 4'b0001, 1'b0, 1'b0);  // 3+1   = 0100, of 0
        set_ops(1'b1, 4'b0010, 4'b0011, 1'b0, 1'b1);  // 2-3   = 1111, of 1
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset req_ready", 32'(req_ready), 32'(2'b00));
        chk("reset rsp_valid", 32'(rsp_valid), 32'(2'b00));
        chk("reset busy", 32'(busy), 32'(1'b0));
        chk("reset rsp_r", 32'(rsp_r), 32'(4'b0000));
        chk("reset rsp_of", 32'(rsp_of), 32'(1'b0));
        chk("reset gnt_id", 32'(gnt_id), 32'(1'b0));

        // Contention right after reset release: grants 0,1,0,1 with rsp_ready=11.
        rsp_ready = 2'b11;
        @(posedge Clk); #1;
        nReset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_g  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_r  = (k % 2 == 0) ? 4'b0100 : 4'b1111;
            exp_of = (k % 2 == 0) ? 1'b0 : 1'b1;
            cyc = 0;
            @(negedge Clk);
            while (req_ready === 2'b00 && cyc < 10) begin
                @(negedge Clk);
                cyc++;
            end
            chk($sformatf("contend%0d grant", k), 32'(req_ready), 32'(exp_g));
            cyc = 0;
            @(negedge Clk);
            while (rsp_valid === 2'b00 && cyc < 10) begin
                if (req_ready === 2'b11) chk("contend req_ready one-hot", 32'(req_ready), 32'(exp_g));
                @(negedge Clk);
                cyc++;
            end
            chk($sformatf("contend%0d rsp_valid", k), 32'(rsp_valid), 32'(exp_g));
            chk($sformatf("contend%0d rsp_r", k), 32'(rsp_r), 32'(exp_r));
            chk($sformatf("contend%0d rsp_of", k), 32'(rsp_of), 32'(exp_of));
        end
        @(posedge Clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(posedge Clk); #1;

        // Table of isolated operations.
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Backpressure: requester 0 held in RESP, requester 1 waiting, wrong-side rsp_ready ignored.
        @(posedge Clk); #1;
        set_ops(1'b0, 4'b0110, 4'b0011, 1'b0, 1'b0);  // 6+3 = 1001, of 0
        set_ops(1'b1, 4'b0100, 4'b0001, 1'b0, 1'b1);  // 4-1 = 0011, of 0
        req_valid = 2'b01;
        @(negedge Clk);
        chk("bp accept", 32'(req_ready), 32'(2'b01));
        @(posedge Clk); #1;
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        cyc = 0;
        @(negedge Clk);
        while (rsp_valid === 2'b00 && cyc < 10) begin
            @(negedge Clk);
            cyc++;
        end
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid), 32'(2'b01));
            chk($sformatf("bp%0d rsp_r", c), 32'(rsp_r), 32'(4'b1001));
            chk($sformatf("bp%0d rsp_of", c), 32'(rsp_of), 32'(1'b0));
            chk($sformatf("bp%0d gnt_id", c), 32'(gnt_id), 32'(1'b0));
            chk($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'(2'b00));
            @(negedge Clk);
        end
        @(posedge Clk); #1;
        rsp_ready = 2'b01;
        @(negedge Clk);
        chk("bp release rsp_valid", 32'(rsp_valid), 32'(2'b01));
        @(posedge Clk); #1;
        rsp_ready = 2'b10;
        @(negedge Clk);
        chk("bp idle rsp_valid", 32'(rsp_valid), 32'(2'b00));
        chk("bp pending accept", 32'(req_ready), 32'(2'b10));
        @(posedge Clk); #1;
        req_valid = 2'b00;
        @(negedge Clk);
        @(negedge Clk);
        chk("bp pending rsp_valid", 32'(rsp_valid), 32'(2'b10));
        chk("bp pending rsp_r", 32'(rsp_r), 32'(4'b0011));
        chk("bp pending rsp_of", 32'(rsp_of), 32'(1'b0));
        @(posedge Clk); #1;
        rsp_ready = 2'b00;

        // Reset during EXEC aborts the op with no response.
        @(posedge Clk); #1;
        set_ops(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0);
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        @(negedge Clk);
        chk("abort accept", 32'(req_ready), 32'(2'b01));
        @(posedge Clk); #1;
        req_valid = 2'b00;
        nReset    = 1'b1;
        @(negedge Clk);
        chk("abort in exec", 32'(busy), 32'(1'b1));
        @(posedge Clk); #1;
        nReset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            chk($sformatf("abort%0d rsp_valid", c), 32'(rsp_valid), 32'(2'b00));
            chk($sformatf("abort%0d busy", c), 32'(busy), 32'(1'b0));
        end
        chk("abort rsp_r cleared", 32'(rsp_r), 32'(4'b0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
